// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the FIFO rinc/rempty/rdata port into a first-word-fall-through valid/ready stream.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds the stall_cnt output.
module fifo_rd_stream #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1,
  localparam int BUF_DEPTH = RD_LAT + 2,
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LVL_W-1:0] buf_level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic [RD_LAT-1:0] trk_valid_reg;
  logic [RD_LAT-1:0] trk_valid_next;
  logic [RD_LAT-1:0] trk_discard_reg;
  logic [RD_LAT-1:0] trk_discard_next;
  logic [LVL_W-1:0]  inflight_cnt;
  logic [LVL_W-1:0]  buf_level_reg;
  logic [LVL_W-1:0]  buf_level_next;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [WIDTH-1:0]  mem [BUF_DEPTH];
  logic [WIDTH-1:0]  m_data_reg;
  logic [WIDTH-1:0]  m_data_next;
  logic              m_valid_reg;
  logic              credit_ok;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // In-flight tracker: one stage per cycle of read latency; flush marks every moving beat for discard.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_trk
    if (gi == 0) begin : g_head
      assign trk_valid_next[gi]   = fifo_rinc;
      assign trk_discard_next[gi] = 1'b0;
    end else begin : g_tail
      assign trk_valid_next[gi]   = trk_valid_reg[gi-1];
      assign trk_discard_next[gi] = trk_discard_reg[gi-1] | flush;
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + LVL_W'(trk_valid_reg[i]);
    end
  end

  // Credit uses registered counts only, so m_ready never reaches fifo_rinc combinationally.
  assign credit_ok = ({1'b0, buf_level_reg} + {1'b0, inflight_cnt}) < (LVL_W + 1)'(BUF_DEPTH);
  assign fifo_rinc = rst_n & ~fifo_rempty & ~flush & credit_ok;

  assign push = trk_valid_reg[RD_LAT-1] & ~trk_discard_reg[RD_LAT-1] & ~flush;
  assign pop  = m_valid_reg & m_ready;

  always_comb begin
    buf_level_next = buf_level_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    if (flush) begin
      buf_level_next = '0;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push && !pop)      buf_level_next = buf_level_reg + 1'b1;
      else if (!push && pop) buf_level_next = buf_level_reg - 1'b1;
    end
  end

  // The new head is the word being written only when it lands at the next read slot.
  always_comb begin
    m_data_next = m_data_reg;
    if (buf_level_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) m_data_next = fifo_rdata;
      else                                     m_data_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid_reg   <= '0;
      trk_discard_reg <= '0;
      buf_level_reg   <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      m_valid_reg     <= 1'b0;
      m_data_reg      <= '0;
    end else begin
      trk_valid_reg   <= trk_valid_next;
      trk_discard_reg <= trk_discard_next;
      buf_level_reg   <= buf_level_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      m_valid_reg     <= (buf_level_next != '0);
      m_data_reg      <= m_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= fifo_rdata;
  end

  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;
  assign buf_level = buf_level_reg;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (flush) begin
      stall_cnt_reg <= '0;
    end else if (m_valid_reg && !m_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (buf_level_reg == LVL_W'(BUF_DEPTH))));

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rinc && fifo_rempty));

endmodule
